// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and line constants for the serial byte tx/rx pair
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } serial_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   DATA_BITS  = 8;

endpackage

// File: rtl/serial_bit_timer.sv
// rtl/serial_bit_timer.sv - per-bit cycle counter, pulses bit_end on the last cycle of each bit
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // With a single cycle per bit the count never leaves zero, so every cycle ends a bit.
  assign bit_end = (count_q == LAST);

  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || bit_end) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_byte_tx.sv
// rtl/serial_byte_tx.sv - start/8-data/[parity]/stop serial transmitter, LSB first, zero-gap back-to-back
module serial_byte_tx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out,
  output logic       busy,
  output logic       done
);

  localparam int IW = $clog2(DATA_BITS);

  serial_state_e          state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [IW-1:0]          bit_idx_q, bit_idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic                   out_q, out_d;
  logic                   bit_end;
  logic                   last_stop;
  logic                   done_w;
  logic                   accept;

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == IDLE),
    .bit_end(bit_end)
  );

  assign last_stop = (stop_idx_q == 1'(STOP_BITS - 1));
  assign done_w    = (state_q == STOP) && bit_end && last_stop;
  assign in_ready  = (state_q == IDLE) || done_w;
  assign accept    = in_valid && in_ready;
  assign done      = done_w;
  assign busy      = (state_q != IDLE);
  assign out       = out_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    case (state_q)
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == IW'(DATA_BITS - 1)) begin
            state_d    = (PARITY_EN != 0) ? PARITY : STOP;
            stop_idx_d = 1'b0;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            state_d = IDLE;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Acceptance on the final stop cycle chains straight into the next start bit.
    if (accept) begin
      state_d  = START;
      shift_d  = in_byte;
      parity_d = ^in_byte;
    end

    case (state_d)
      START:   out_d = START_BIT;
      DATA:    out_d = shift_d[0];
      PARITY:  out_d = parity_d;
      IDLE:    out_d = IDLE_LEVEL;
      default: out_d = STOP_BIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      out_q      <= IDLE_LEVEL;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      out_q      <= out_d;
    end
  end

endmodule

// File: tb/tb_serial_byte_tx.sv
// tb/tb_serial_byte_tx.sv - directed and loopback bench for serial_byte_tx in three configurations
module tb_serial_byte_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_ps;
  logic [7:0] byte_a, byte_p, byte_s;
  logic       valid_a, valid_p, valid_s;
  logic       ready_a, ready_p, ready_s;
  logic       out_a, out_p, out_s;
  logic       busy_a, busy_p, busy_s;
  logic       done_a, done_p, done_s;

  int checks = 0;
  int errors = 0;

  serial_byte_tx u_def (
    .clk(clk), .reset(rst_a), .in_byte(byte_a), .in_valid(valid_a),
    .in_ready(ready_a), .out(out_a), .busy(busy_a), .done(done_a)
  );

  serial_byte_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1), .STOP_BITS(1)) u_par (
    .clk(clk), .reset(rst_ps), .in_byte(byte_p), .in_valid(valid_p),
    .in_ready(ready_p), .out(out_p), .busy(busy_p), .done(done_p)
  );

  serial_byte_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(2)) u_slow (
    .clk(clk), .reset(rst_ps), .in_byte(byte_s), .in_valid(valid_s),
    .in_ready(ready_s), .out(out_s), .busy(busy_s), .done(done_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_out(input int sel);
    case (sel)
      0:       return out_a;
      1:       return out_p;
      default: return out_s;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return done_a;
      1:       return done_p;
      default: return done_s;
    endcase
  endfunction

  function automatic logic get_ready(input int sel);
    case (sel)
      0:       return ready_a;
      1:       return ready_p;
      default: return ready_s;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_p;
      default: return busy_s;
    endcase
  endfunction

  // Called at a negedge; the following posedge is the acceptance edge.
  task automatic start_frame(input int sel, input logic [7:0] b);
    case (sel)
      0:       begin byte_a = b; valid_a = 1'b1; end
      1:       begin byte_p = b; valid_p = 1'b1; end
      default: begin byte_s = b; valid_s = 1'b1; end
    endcase
    @(posedge clk);
  endtask

  task automatic run_frame(input int sel, input string tag, input logic [63:0] exp_bits,
                           input int nbits, input int cpb);
    int total;
    int dcnt;
    int done_at;
    int ready_at;
    total    = nbits * cpb;
    dcnt     = 0;
    done_at  = -1;
    ready_at = -1;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      if (k == 1) begin
        valid_a = 1'b0;
        valid_p = 1'b0;
        valid_s = 1'b0;
      end
      check({tag, "_out"}, 32'(get_out(sel)), 32'(exp_bits[(k-1)/cpb]));
      if (get_done(sel)) begin
        dcnt++;
        done_at = k;
      end
      if (get_ready(sel) && ready_at < 0) ready_at = k;
    end
    check({tag, "_done_cnt"}, 32'(dcnt), 32'd1);
    check({tag, "_done_at"}, 32'(done_at), 32'(total));
    check({tag, "_ready_at"}, 32'(ready_at), 32'(total));
    @(negedge clk);
    check({tag, "_busy_end"}, 32'(get_busy(sel)), 32'd0);
    check({tag, "_out_end"}, 32'(get_out(sel)), 32'd1);
  endtask

  initial begin
    logic [19:0] b2b_bits;
    logic [9:0]  rst_bits;
    int          dcnt;
    int          sent;
    int          rxn;
    int          lb_bad;
    int          gap;
    int          rx_st;
    logic        pend;
    logic [7:0]  rx_b;
    logic [7:0]  q[$];

    rst_a = 1'b1; rst_ps = 1'b1;
    byte_a = '0; byte_p = '0; byte_s = '0;
    valid_a = 1'b0; valid_p = 1'b0; valid_s = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out", 32'(out_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_ready", 32'(ready_a), 32'd1);
    check("rst_out_slow", 32'(out_s), 32'd1);
    check("rst_busy_par", 32'(busy_p), 32'd0);
    rst_a = 1'b0; rst_ps = 1'b0;
    @(negedge clk);

    start_frame(0, 8'hA5);
    run_frame(0, "a5", 64'(10'b1_10100101_0), 10, 1);

    // Back-to-back 0x00 then 0xFF with in_valid held.
    b2b_bits = 20'b1_11111111_0_1_00000000_0;
    byte_a = 8'h00; valid_a = 1'b1;
    @(posedge clk);
    dcnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check("b2b_out", 32'(out_a), 32'(b2b_bits[k-1]));
      if (done_a) dcnt++;
      if (k == 10 || k == 20) check("b2b_done", 32'(done_a), 32'd1);
      if (k == 1) byte_a = 8'hFF;
      if (k == 11) valid_a = 1'b0;
    end
    check("b2b_done_cnt", 32'(dcnt), 32'd2);
    @(negedge clk);
    check("b2b_busy_end", 32'(busy_a), 32'd0);

    start_frame(1, 8'h07);
    run_frame(1, "par07", 64'(11'b1_1_00000111_0), 11, 1);
    start_frame(1, 8'h03);
    run_frame(1, "par03", 64'(11'b1_0_00000011_0), 11, 1);

    start_frame(2, 8'h3C);
    run_frame(2, "slow3c", 64'(11'b11_00111100_0), 11, 4);

    // Reset during data bit 3 of 0x81.
    rst_bits = 10'b1_10000001_0;
    dcnt = 0;
    start_frame(0, 8'h81);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) valid_a = 1'b0;
      check("rst81_out", 32'(out_a), 32'(rst_bits[k-1]));
      if (done_a) dcnt++;
    end
    rst_a = 1'b1;
    @(negedge clk);
    if (done_a) dcnt++;
    check("midrst_out", 32'(out_a), 32'd1);
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_no_done", 32'(dcnt), 32'd0);
    rst_a = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(ready_a), 32'd1);
    start_frame(0, 8'h55);
    run_frame(0, "post_rst55", 64'(10'b1_01010101_0), 10, 1);

    // Loopback into a bench-side receiver with random producer gaps.
    sent = 0; rxn = 0; lb_bad = 0; gap = 0; rx_st = 0; pend = 1'b0; rx_b = '0;
    for (int cyc = 0; cyc < 20000 && rxn < 256; cyc++) begin
      @(negedge clk);
      if (rx_st == 0) begin
        if (done_a) lb_bad++;
        if (!out_a) rx_st = 1;
      end else if (rx_st <= 8) begin
        if (done_a) lb_bad++;
        rx_b[rx_st-1] = out_a;
        rx_st++;
      end else begin
        if (!out_a || !done_a) lb_bad++;
        if (q.size() == 0) lb_bad++;
        else if (q.pop_front() != rx_b) lb_bad++;
        rxn++;
        rx_st = 0;
      end
      if (pend) begin
        q.push_back(byte_a);
        sent++;
        valid_a = 1'b0;
        gap = $urandom_range(0, 3);
      end
      if (!valid_a && sent < 256) begin
        if (gap > 0) gap--;
        else begin
          byte_a  = 8'($urandom_range(0, 255));
          valid_a = 1'b1;
        end
      end
      pend = valid_a && ready_a;
    end
    valid_a = 1'b0;
    check("lb_count", 32'(rxn), 32'd256);
    check("lb_bad", 32'(lb_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_byte_tx.md
Name: serial_byte_tx

Overview:
Serial byte transmitter; the transmit end of the team's start/8-data/stop serial line.
- Accepts parallel bytes on a valid/ready handshake and shifts each out LSB first.
- Frame: one start bit (0), eight data bits, optional even parity bit, one or two stop bits (1). Line idles at 1.
- Output feeds the team's serial byte receiver directly. Back-to-back frames carry no idle gap.

Parameters:
- CLKS_PER_BIT, 1: clock cycles per serial bit. Legal range 1..65535.
- PARITY_EN, 0: 1 inserts an even-parity bit after bit 7.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  input  1: single clock; all logic is on the rising edge.
- reset  input  1: synchronous, active-high reset.
- in_byte  input  8: byte to send. Sampled only on acceptance.
- in_valid  input  1: producer holds a byte.
- in_ready  output  1: transmitter can accept a byte this cycle.
- out  output  1: serial line, registered.
- busy  output  1: a frame is in progress.
- done  output  1: one-cycle pulse on the final cycle of the last stop bit.

Behaviour:
- Reset (synchronous, clk edge with reset=1): state IDLE, out=1, busy=0, done=0, in_ready=1, bit timer=0. Reset overrides acceptance in the same cycle.
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance: in_valid && in_ready at a clk edge.
  - Latches in_byte into a shift register.
  - Next cycle enters START with out=0.
  - in_byte changes after acceptance have no effect.
- Bit timer: counts 0..CLKS_PER_BIT-1 and resets at every bit boundary. Each bit holds on out for exactly CLKS_PER_BIT cycles.
- START: out=0 for one bit time, then DATA.
- DATA: bit index 0..7. out = shift[0], LSB first; shift right at each bit boundary. After bit 7, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: out = XOR of the latched 8 bits, so the total count of ones in data plus parity is even. Lasts one bit time, then STOP.
- STOP: out=1 for STOP_BITS bit times. On the final cycle of the final stop bit:
  - done=1 and in_ready=1.
  - If a byte is accepted, next state is START, so the next start bit follows with zero gap.
  - Otherwise next state is IDLE.
- in_ready: combinational. High in IDLE or on the final STOP cycle; low otherwise.
- busy: 1 in START/DATA/PARITY/STOP, 0 in IDLE.
- out latency: first start-bit cycle is exactly 1 cycle after the acceptance edge.
- Frame length: (10 + PARITY_EN + STOP_BITS - 1) * CLKS_PER_BIT cycles.
- Reset mid-frame: the frame is abandoned. out returns to 1 on the reset edge, no done pulse, and in_ready is 1 the next cycle.
- in_valid with in_ready=0: ignored; the producer must hold the byte.
- Bit timer width: clog2(CLKS_PER_BIT) bits, minimum 1. When CLKS_PER_BIT=1, every cycle is a bit boundary.

Decomposition:
- Shared package serial_pkg:
  - State enum {IDLE, START, DATA, PARITY, STOP}.
  - Constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1, DATA_BITS=8.
  - The receiver also uses this package.
- One sub-module, serial_bit_timer: parameter CLKS_PER_BIT; inputs clk, reset, clear; output bit_end pulse. The same module is reusable by the receiver.
- The FSM, shift register and parity logic stay in serial_byte_tx.

Test Plan:
- Single byte, defaults: 0xA5 accepted at edge T.
  - out for cycles T+1..T+10 = 0,1,0,1,0,0,1,0,1,1.
  - done=1 at T+10; busy=0 and out=1 at T+11.
- Back-to-back, defaults: in_valid held with 0x00 then 0xFF.
  - out = 0,0000 0000,1,0,1111 1111,1 over 20 consecutive cycles, no idle gap.
  - Exactly two done pulses, at cycles 10 and 20.
- Parity, PARITY_EN=1:
  - 0x07 gives parity bit 1 at the 10th bit time.
  - 0x03 gives parity bit 0.
  - Frame is 11 bits.
- Timing, CLKS_PER_BIT=4, STOP_BITS=2:
  - 0x3C gives each bit held for exactly 4 cycles.
  - Frame is 44 cycles.
  - in_ready stays low until the final stop cycle.
- Reset mid-frame: assert reset during data bit 3 of 0x81.
  - out=1 and busy=0 after the reset edge, no done pulse.
  - A new byte 0x55 is accepted the cycle after reset deasserts and sent correctly.
- Loopback: out feeds the serial byte receiver with 256 random bytes and random in_valid gaps.
  - Every receiver done asserts with out_byte equal to the sent byte, in order.
